instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit.sv | 157 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time and hands instructions to decode.
// Optional misaligned-redirect trap is compiled in with FETCH_MISALIGN_TRAP_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic        imemRspValid,
  input  logic [31:0] imemRspData,
  output logic [31:0] instr,
  output logic [31:0] instrPc,
  output logic [31:0] instrPcPlus4,
  output logic        instrValid,
  input  logic        decodeReady,
  input  logic        redirect,
  input  logic [31:0] redirectPc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetchFault,
  output logic [31:0] faultPc
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    FAULT
`endif
  } state_t;

  state_t      state, stateNext;
  logic [31:0] pc, pcNext;
  logic        drop, dropNext;
  logic [31:0] instrNext, instrPcNext;
  logic        instrValidNext;
  logic [31:0] target;
  logic        redirectTaken;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetchFaultNext;
  logic [31:0] faultPcNext;
`endif

  assign instrPcPlus4 = instrPc + 32'd4;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign target        = redirectPc;
  assign redirectTaken = redirect && (state != FAULT);
`else
  assign target        = redirectPc & ~32'h3;
  assign redirectTaken = redirect;
`endif

  always_comb begin
    stateNext      = state;
    pcNext         = pc;
    dropNext       = drop;
    instrNext      = instr;
    instrPcNext    = instrPc;
    instrValidNext = instrValid;
`ifdef FETCH_MISALIGN_TRAP_EN
    fetchFaultNext = fetchFault;
    faultPcNext    = faultPc;
`endif
    if (redirectTaken) begin
      // A redirect never consumes the held instruction and always refetches.
      pcNext         = target;
      instrValidNext = 1'b0;
      case (state)
        REQ: begin
          stateNext = imemReady ? WAIT : REQ;
          dropNext  = imemReady;
        end
        WAIT: begin
          stateNext = imemRspValid ? REQ : WAIT;
          dropNext  = !imemRspValid;
        end
        default: begin
          stateNext = REQ;
          dropNext  = 1'b0;
        end
      endcase
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redirectPc[1:0] != 2'b00) begin
        stateNext      = FAULT;
        dropNext       = 1'b0;
        fetchFaultNext = 1'b1;
        faultPcNext    = redirectPc;
      end
`endif
    end else begin
      case (state)
        IDLE: stateNext = REQ;
        REQ:  if (imemReady) stateNext = WAIT;
        WAIT: begin
          if (imemRspValid) begin
            if (drop) begin
              dropNext  = 1'b0;
              stateNext = REQ;
            end else begin
              instrNext      = imemRspData;
              instrPcNext    = pc;
              instrValidNext = 1'b1;
              stateNext      = HOLD;
            end
          end
        end
        HOLD: begin
          if (decodeReady) begin
            instrValidNext = 1'b0;
            pcNext         = pc + 32'd4;
            stateNext      = REQ;
          end
        end
        default: stateNext = state;
      endcase
    end
  end

  // Request outputs are registered from the next state so they never see inputs combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      drop       <= 1'b0;
      imemReq    <= 1'b0;
      imemAddr   <= RESET_PC;
      instr      <= 32'h0;
      instrPc    <= RESET_PC;
      instrValid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fetchFault <= 1'b0;
      faultPc    <= 32'h0;
`endif
    end else begin
      state      <= stateNext;
      pc         <= pcNext;
      drop       <= dropNext;
      imemReq    <= (stateNext == REQ);
      imemAddr   <= pcNext;
      instr      <= instrNext;
      instrPc    <= instrPcNext;
      instrValid <= instrValidNext;
`ifdef FETCH_MISALIGN_TRAP_EN
      fetchFault <= fetchFaultNext;
      faultPc    <= faultPcNext;
`endif
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
// Honors FETCH_MISALIGN_TRAP_EN for the misaligned-redirect scenario.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic        imemRspValid;
  logic [31:0] imemRspData;
  logic [31:0] instr;
  logic [31:0] instrPc;
  logic [31:0] instrPcPlus4;
  logic        instrValid;
  logic        decodeReady;
  logic        redirect;
  logic [31:0] redirectPc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetchFault;
  logic [31:0] faultPc;
`endif

  int total = 0;
  int bad   = 0;

  instr_fetch_unit dut (
    .clk(clk), .reset(reset),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemReady(imemReady),
    .imemRspValid(imemRspValid), .imemRspData(imemRspData),
    .instr(instr), .instrPc(instrPc), .instrPcPlus4(instrPcPlus4),
    .instrValid(instrValid), .decodeReady(decodeReady),
    .redirect(redirect), .redirectPc(redirectPc)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .fetchFault(fetchFault), .faultPc(faultPc)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; imemReady = 0; imemRspValid = 0; imemRspData = 0;
    decodeReady = 0; redirect = 0; redirectPc = 0;
    step(); step();
    total++; if (imemReq !== 1'b0) begin bad++; $display("[TB] FAIL rst_req got=%b exp=0", imemReq); end
    total++; if (imemAddr !== 32'h0) begin bad++; $display("[TB] FAIL rst_addr got=%h exp=0", imemAddr); end
    total++; if (instrValid !== 1'b0) begin bad++; $display("[TB] FAIL rst_valid got=%b exp=0", instrValid); end
    total++; if (instr !== 32'h0) begin bad++; $display("[TB] FAIL rst_instr got=%h exp=0", instr); end
    total++; if (instrPcPlus4 !== 32'h4) begin bad++; $display("[TB] FAIL rst_pc4 got=%h exp=4", instrPcPlus4); end
    reset = 1'b0;
  endtask

  task automatic test_basic_fetch();
    step();
    total++; if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin bad++; $display("[TB] FAIL first_req got=%b/%h exp=1/0", imemReq, imemAddr); end
    imemReady = 1;
    step();
    total++; if (imemReq !== 1'b0) begin bad++; $display("[TB] FAIL wait_req got=%b exp=0", imemReq); end
    imemReady = 0; imemRspValid = 1; imemRspData = 32'h00500093;
    step();
    imemRspValid = 0;
    total++; if (instrValid !== 1'b1 || instr !== 32'h00500093) begin bad++; $display("[TB] FAIL first_instr got=%b/%h exp=1/00500093", instrValid, instr); end
    total++; if (instrPc !== 32'h0 || instrPcPlus4 !== 32'h4) begin bad++; $display("[TB] FAIL first_pc got=%h/%h exp=0/4", instrPc, instrPcPlus4); end
    decodeReady = 1;
    step();
    decodeReady = 0;
    total++; if (imemReq !== 1'b1 || imemAddr !== 32'h4 || instrValid !== 1'b0) begin bad++; $display("[TB] FAIL next_req got=%b/%h/%b exp=1/4/0", imemReq, imemAddr, instrValid); end
  endtask

  task automatic test_hold_stall();
    imemReady = 1; step();
    imemReady = 0; imemRspValid = 1; imemRspData = 32'h00A00113; step();
    imemRspValid = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (instrValid !== 1'b1 || instr !== 32'h00A00113 || instrPc !== 32'h4 || imemReq !== 1'b0) begin
        bad++; $display("[TB] FAIL hold_stable%0d got=%b/%h/%h/%b exp=1/00a00113/4/0", i, instrValid, instr, instrPc, imemReq);
      end
    end
    decodeReady = 1; step(); decodeReady = 0;
    total++; if (imemReq !== 1'b1 || imemAddr !== 32'h8) begin bad++; $display("[TB] FAIL hold_next got=%b/%h exp=1/8", imemReq, imemAddr); end
  endtask

  task automatic test_redirect_wait();
    imemReady = 1; step();
    imemReady = 0; redirect = 1; redirectPc = 32'h100; step();
    redirect = 0;
    total++; if (imemReq !== 1'b0) begin bad++; $display("[TB] FAIL rw_req got=%b exp=0", imemReq); end
    imemRspValid = 1; imemRspData = 32'hDEADBEEF; step();
    imemRspValid = 0;
    total++; if (instrValid !== 1'b0) begin bad++; $display("[TB] FAIL rw_stale_valid got=%b exp=0", instrValid); end
    total++; if (imemReq !== 1'b1 || imemAddr !== 32'h100) begin bad++; $display("[TB] FAIL rw_addr got=%b/%h exp=1/100", imemReq, imemAddr); end
  endtask

  task automatic test_redirect_same_cycle();
    imemReady = 1; step();
    imemReady = 0; redirect = 1; redirectPc = 32'h40; imemRspValid = 1; imemRspData = 32'h11111111; step();
    redirect = 0; imemRspValid = 0;
    total++; if (instrValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 32'h40) begin bad++; $display("[TB] FAIL rs_req got=%b/%b/%h exp=0/1/40", instrValid, imemReq, imemAddr); end
    imemReady = 1; step();
    imemReady = 0; imemRspValid = 1; imemRspData = 32'h00000013; step();
    imemRspValid = 0;
    total++; if (instrValid !== 1'b1 || instr !== 32'h13 || instrPc !== 32'h40) begin bad++; $display("[TB] FAIL rs_fetch got=%b/%h/%h exp=1/13/40", instrValid, instr, instrPc); end
  endtask

  task automatic test_redirect_hold();
    redirect = 1; redirectPc = 32'h200; decodeReady = 1; step();
    redirect = 0; decodeReady = 0;
    total++; if (instrValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 32'h200) begin bad++; $display("[TB] FAIL rh_req got=%b/%b/%h exp=0/1/200", instrValid, imemReq, imemAddr); end
    imemReady = 1; step();
    imemReady = 0; imemRspValid = 1; imemRspData = 32'h00208233; step();
    imemRspValid = 0;
    total++; if (instrPc !== 32'h200 || instrPcPlus4 !== 32'h204) begin bad++; $display("[TB] FAIL rh_pc got=%h/%h exp=200/204", instrPc, instrPcPlus4); end
    decodeReady = 1; step(); decodeReady = 0;
    total++; if (imemAddr !== 32'h204) begin bad++; $display("[TB] FAIL rh_next got=%h exp=204", imemAddr); end
  endtask

  task automatic test_redirect_req();
    redirect = 1; redirectPc = 32'h300; step();
    redirect = 0;
    total++; if (imemReq !== 1'b1 || imemAddr !== 32'h300) begin bad++; $display("[TB] FAIL rq_addr got=%b/%h exp=1/300", imemReq, imemAddr); end
  endtask

  task automatic test_wrap();
    redirect = 1; redirectPc = 32'hFFFF_FFFC; step();
    redirect = 0;
    imemReady = 1; step();
    imemReady = 0; imemRspValid = 1; imemRspData = 32'h00000073; step();
    imemRspValid = 0;
    total++; if (instrPc !== 32'hFFFF_FFFC || instrPcPlus4 !== 32'h0) begin bad++; $display("[TB] FAIL wrap_pc got=%h/%h exp=fffffffc/0", instrPc, instrPcPlus4); end
    decodeReady = 1; step(); decodeReady = 0;
    total++; if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin bad++; $display("[TB] FAIL wrap_addr got=%b/%h exp=1/0", imemReq, imemAddr); end
  endtask

  task automatic test_misalign();
    redirect = 1; redirectPc = 32'h102; step();
    redirect = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
    total++; if (fetchFault !== 1'b1 || faultPc !== 32'h102) begin bad++; $display("[TB] FAIL mis_fault got=%b/%h exp=1/102", fetchFault, faultPc); end
    imemReady = 1; imemRspValid = 1; imemRspData = 32'h00000013;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (imemReq !== 1'b0 || instrValid !== 1'b0 || fetchFault !== 1'b1) begin
        bad++; $display("[TB] FAIL mis_hold%0d got=%b/%b/%b exp=0/0/1", i, imemReq, instrValid, fetchFault);
      end
    end
    imemReady = 0; imemRspValid = 0;
`else
    total++; if (imemReq !== 1'b1 || imemAddr !== 32'h100) begin bad++; $display("[TB] FAIL mis_align got=%b/%h exp=1/100", imemReq, imemAddr); end
    imemReady = 1; step();
    imemReady = 0; imemRspValid = 1; imemRspData = 32'h00000093; step();
    imemRspValid = 0;
    total++; if (instrValid !== 1'b1 || instrPc !== 32'h100) begin bad++; $display("[TB] FAIL mis_fetch got=%b/%h exp=1/100", instrValid, instrPc); end
`endif
  endtask

  task automatic test_async_reset();
    #2 reset = 1'b1;
    #1;
    total++; if (instrValid !== 1'b0 || instr !== 32'h0 || instrPc !== 32'h0) begin bad++; $display("[TB] FAIL arst_instr got=%b/%h/%h exp=0/0/0", instrValid, instr, instrPc); end
    total++; if (imemReq !== 1'b0 || imemAddr !== 32'h0) begin bad++; $display("[TB] FAIL arst_req got=%b/%h exp=0/0", imemReq, imemAddr); end
`ifdef FETCH_MISALIGN_TRAP_EN
    total++; if (fetchFault !== 1'b0 || faultPc !== 32'h0) begin bad++; $display("[TB] FAIL arst_fault got=%b/%h exp=0/0", fetchFault, faultPc); end
`endif
    step();
    reset = 1'b0;
    step();
    total++; if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin bad++; $display("[TB] FAIL arst_restart got=%b/%h exp=1/0", imemReq, imemAddr); end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_hold_stall();
    test_redirect_wait();
    test_redirect_same_cycle();
    test_redirect_hold();
    test_redirect_req();
    test_wrap();
    test_misalign();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
